// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and default constants for the fetch sequencer.
//   state_t       : sequencer states IDLE, RUN, STALL, DONE
//   PC_W_DEF      : default program-counter width
//   HALT_CODE_DEF : default instruction encoding that ends the program
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int         PC_W_DEF      = 10;
    localparam logic [8:0] HALT_CODE_DEF = 9'h1FF;
endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// fetch_sequencer_next_pc: picks the next instruction address.
//   pc        : current program counter
//   branch_en : current instruction is a conditional branch
//   zero      : ALU zero flag (branch taken when set)
//   target    : absolute branch target
//   nxt       : target when the branch is taken, otherwise pc+1 wrapping at 2^PC_W
module fetch_sequencer_next_pc #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch_en,
    input  logic            zero,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] nxt
);
    assign nxt = (branch_en & zero) ? target : pc + 1'b1;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch sequencing (start, halt, stall) for the 9-bit core.
//   Clk, Reset   : clock and synchronous active-high reset
//   Start        : pulse that (re)starts the program at address 0 from IDLE or DONE
//   Instruction  : machine code fetched at ProgCtr
//   BranchEn     : decoder flag for a conditional branch
//   Zero         : ALU zero flag, takes the branch when set
//   BranchTarget : absolute branch target
//   Stall        : data memory busy, current instruction not complete
//   ProgCtr      : registered instruction address
//   InstrValid   : high only in RUN
//   Done         : registered, high once HALT_CODE has executed
//   CycleCnt     : saturating count of RUN/STALL edges since the last Start
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int         PC_W      = PC_W_DEF,
    parameter int         CNT_W     = 16,
    parameter logic [8:0] HALT_CODE = HALT_CODE_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       Instruction,
    input  logic             BranchEn,
    input  logic             Zero,
    input  logic [PC_W-1:0]  BranchTarget,
    input  logic             Stall,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);
    state_t           state, state_n;
    logic [PC_W-1:0]  pc_n, pc_adv;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic             done_n;

    // Shared by the RUN advance and the STALL release paths.
    fetch_sequencer_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc        (ProgCtr),
        .branch_en (BranchEn),
        .zero      (Zero),
        .target    (BranchTarget),
        .nxt       (pc_adv)
    );

    assign cnt_inc    = &CycleCnt ? CycleCnt : CycleCnt + 1'b1;
    assign InstrValid = (state == RUN);

    always_comb begin
        state_n = state;
        pc_n    = ProgCtr;
        done_n  = Done;
        cnt_n   = CycleCnt;
        unique case (state)
            IDLE: begin
                pc_n = '0;
                if (Start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                end
            end
            RUN: begin
                cnt_n = cnt_inc;
                // Halt outranks stall and branch; Start is ignored here.
                if (Instruction == HALT_CODE) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (Stall) begin
                    state_n = STALL;
                end else begin
                    pc_n = pc_adv;
                end
            end
            STALL: begin
                cnt_n = cnt_inc;
                if (!Stall) begin
                    state_n = RUN;
                    pc_n    = pc_adv;
                end
            end
            DONE: begin
                if (Start) begin
                    state_n = RUN;
                    pc_n    = '0;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ProgCtr  <= '0;
            Done     <= 1'b0;
            CycleCnt <= '0;
        end else begin
            state    <= state_n;
            ProgCtr  <= pc_n;
            Done     <= done_n;
            CycleCnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer (PC_W=10 main instance, PC_W=4/CNT_W=4 wrap instance).
module tb_fetch_sequencer;
    typedef struct {
        logic [9:0]  pc;
        logic        v;
        logic        d;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [8:0]  Instruction = 9'h000;
    logic        BranchEn = 1'b0;
    logic        Zero = 1'b0;
    logic [9:0]  BranchTarget = 10'd0;
    logic        Stall = 1'b0;
    logic [9:0]  ProgCtr;
    logic        InstrValid;
    logic        Done;
    logic [15:0] CycleCnt;

    logic        Start4 = 1'b0;
    logic [3:0]  ProgCtr4;
    logic        InstrValid4;
    logic        Done4;
    logic [3:0]  CycleCnt4;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    fetch_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
        .BranchEn(BranchEn), .Zero(Zero), .BranchTarget(BranchTarget), .Stall(Stall),
        .ProgCtr(ProgCtr), .InstrValid(InstrValid), .Done(Done), .CycleCnt(CycleCnt)
    );

    fetch_sequencer #(.PC_W(4), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .Instruction(9'h000),
        .BranchEn(1'b0), .Zero(1'b0), .BranchTarget(4'd0), .Stall(1'b0),
        .ProgCtr(ProgCtr4), .InstrValid(InstrValid4), .Done(Done4), .CycleCnt(CycleCnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [9:0] pc, input logic v, input logic d, input logic [15:0] cnt);
        exp_t e;
        e.pc = pc; e.v = v; e.d = d; e.cnt = cnt; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop(output exp_t e, output bit ok);
        ok = sb.size() != 0;
        if (ok) e = sb.pop_front();
        else begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
    endtask

    // One clock of stimulus on the main instance with the state expected after the edge.
    task automatic cyc(input string tag, input logic rst, input logic st, input logic [8:0] ins,
                       input logic be, input logic z, input logic [9:0] tgt, input logic stl,
                       input logic [9:0] epc, input logic ev, input logic ed, input logic [15:0] ec);
        exp_t e;
        bit   ok;
        Reset = rst; Start = st; Instruction = ins; BranchEn = be; Zero = z;
        BranchTarget = tgt; Stall = stl;
        push(tag, epc, ev, ed, ec);
        @(posedge Clk); #1;
        pop(e, ok);
        if (ok) begin
            chk({e.tag, ".pc"},    32'(ProgCtr),    32'(e.pc));
            chk({e.tag, ".valid"}, 32'(InstrValid), 32'(e.v));
            chk({e.tag, ".done"},  32'(Done),       32'(e.d));
            chk({e.tag, ".cnt"},   32'(CycleCnt),   32'(e.cnt));
        end
    endtask

    localparam logic [8:0] OP   = 9'h012;
    localparam logic [8:0] HALT = 9'h1FF;

    initial begin
        exp_t e;
        bit   ok;
        @(posedge Clk); #1;
        cyc("reset",        1, 0, OP,    0, 0, 10'd0,  0, 10'd0,  0, 0, 16'd0);
        cyc("idle_x",       0, 0, 'x,    0, 0, 10'd0,  0, 10'd0,  0, 0, 16'd0);
        cyc("start",        0, 1, OP,    0, 0, 10'd0,  0, 10'd0,  1, 0, 16'd0);
        cyc("seq1",         0, 0, OP,    0, 0, 10'd0,  0, 10'd1,  1, 0, 16'd1);
        cyc("seq2",         0, 0, OP,    0, 0, 10'd0,  0, 10'd2,  1, 0, 16'd2);
        cyc("seq3",         0, 0, OP,    0, 0, 10'd0,  0, 10'd3,  1, 0, 16'd3);
        cyc("halt",         0, 0, HALT,  0, 0, 10'd0,  0, 10'd3,  0, 1, 16'd4);
        cyc("done_hold",    0, 0, 'x,    0, 0, 10'd0,  0, 10'd3,  0, 1, 16'd4);
        cyc("restart",      0, 1, 'x,    0, 0, 10'd0,  0, 10'd0,  1, 0, 16'd0);
        cyc("br_to5",       0, 0, OP,    1, 1, 10'd5,  0, 10'd5,  1, 0, 16'd1);
        cyc("br_taken",     0, 0, OP,    1, 1, 10'd40, 0, 10'd40, 1, 0, 16'd2);
        cyc("br_back5",     0, 0, OP,    1, 1, 10'd5,  0, 10'd5,  1, 0, 16'd3);
        cyc("br_nottaken",  0, 0, OP,    1, 0, 10'd40, 0, 10'd6,  1, 0, 16'd4);
        cyc("start_in_run", 0, 1, OP,    0, 0, 10'd0,  0, 10'd7,  1, 0, 16'd5);
        cyc("stall1",       0, 0, OP,    0, 0, 10'd0,  1, 10'd7,  0, 0, 16'd6);
        cyc("stall2",       0, 0, OP,    0, 0, 10'd0,  1, 10'd7,  0, 0, 16'd7);
        cyc("stall3",       0, 0, HALT,  0, 0, 10'd0,  1, 10'd7,  0, 0, 16'd8);
        cyc("stall_rel",    0, 0, OP,    0, 0, 10'd0,  0, 10'd8,  1, 0, 16'd9);
        cyc("stall_b",      0, 0, OP,    1, 1, 10'd12, 1, 10'd8,  0, 0, 16'd10);
        cyc("stall_rel_br", 0, 0, OP,    1, 1, 10'd12, 0, 10'd12, 1, 0, 16'd11);
        cyc("stall_at12",   0, 0, OP,    0, 0, 10'd0,  1, 10'd12, 0, 0, 16'd12);
        cyc("reset_stall",  1, 1, OP,    0, 0, 10'd0,  1, 10'd0,  0, 0, 16'd0);
        cyc("start_lost",   0, 0, 'x,    0, 0, 10'd0,  0, 10'd0,  0, 0, 16'd0);
        cyc("start_again",  0, 1, OP,    0, 0, 10'd0,  0, 10'd0,  1, 0, 16'd0);
        cyc("seq_again",    0, 0, OP,    0, 0, 10'd0,  0, 10'd1,  1, 0, 16'd1);
        cyc("halt_vs_stall",0, 0, HALT,  1, 1, 10'd9,  1, 10'd1,  0, 1, 16'd2);
        cyc("done_stall",   0, 0, OP,    0, 0, 10'd0,  1, 10'd1,  0, 1, 16'd2);

        // Narrow instance: straight-line code wraps 15->0, counter saturates at 15.
        Start4 = 1'b1;
        push("w4_start", 10'd0, 1, 0, 16'd0);
        @(posedge Clk); #1;
        Start4 = 1'b0;
        pop(e, ok);
        if (ok) begin
            chk({e.tag, ".pc"},    32'(ProgCtr4),    32'(e.pc));
            chk({e.tag, ".valid"}, 32'(InstrValid4), 32'(e.v));
            chk({e.tag, ".cnt"},   32'(CycleCnt4),   32'(e.cnt));
        end
        for (int i = 1; i <= 18; i++) begin
            push($sformatf("w4_%0d", i), 10'(i % 16), 1, 0, 16'(i > 15 ? 15 : i));
            @(posedge Clk); #1;
            pop(e, ok);
            if (ok) begin
                chk({e.tag, ".pc"},   32'(ProgCtr4),  32'(e.pc));
                chk({e.tag, ".done"}, 32'(Done4),     32'(e.d));
                chk({e.tag, ".cnt"},  32'(CycleCnt4), 32'(e.cnt));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter and fetch sequencer for the 9-bit single-cycle core.
- Owns ProgCtr, which addresses the instruction ROM.
- Consumes BranchEn from the combinational control decoder and the ALU Zero flag.
- Sequences program start, halt, and data-memory stalls, and reports Done and a cycle count to the testbench/top level.

Parameters:
PC_W, 10, width of ProgCtr (instruction ROM depth 2^PC_W)
CNT_W, 16, width of the executed-cycle counter
HALT_CODE, 9'h1FF, instruction encoding that terminates the program

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  single-cycle pulse: begin/restart program at address 0
Instruction  input  9  machine code currently fetched at ProgCtr
BranchEn  input  1  decoder flag: current instruction is a conditional branch
Zero  input  1  ALU zero flag for the current instruction (branch taken when 1)
BranchTarget  input  PC_W  absolute target from the branch lookup table
Stall  input  1  data memory busy; current instruction not yet complete
ProgCtr  output  PC_W  registered instruction address
InstrValid  output  1  Instruction at ProgCtr is executing this cycle
Done  output  1  registered; program has reached HALT_CODE
CycleCnt  output  CNT_W  cycles spent in RUN+STALL since last Start

Behaviour:
- Single clock Clk. Reset is synchronous and active-high.
  - Reset=1 at an edge gives: state IDLE, ProgCtr=0, Done=0, CycleCnt=0.
  - This holds from any state, including mid-RUN or mid-STALL.
- InstrValid is combinational from state: 1 only in RUN.
- States: IDLE, RUN, STALL, DONE.
- IDLE: ProgCtr held 0. Start=1 -> RUN; ProgCtr=0, CycleCnt=0.
- RUN (per edge, priority order):
  1. Instruction==HALT_CODE -> DONE; ProgCtr held; Done=1 next cycle.
  2. Stall=1 -> STALL; ProgCtr held.
  3. BranchEn=1 and Zero=1 -> ProgCtr<=BranchTarget.
  4. Otherwise ProgCtr<=ProgCtr+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
  - Start is ignored in RUN.
- STALL:
  - While Stall=1: hold ProgCtr and stay in STALL.
  - On the first edge with Stall=0: compute next ProgCtr using rules 3/4 on the current inputs, and go to RUN.
  - HALT_CODE is not checked in STALL.
- DONE:
  - Done=1; ProgCtr and CycleCnt frozen.
  - Start=1 -> RUN with ProgCtr=0, CycleCnt=0, Done=0 on the same edge.
- CycleCnt:
  - Increments by 1 on every edge taken in RUN or STALL, including the HALT edge.
  - Saturates at 2^CNT_W-1; no wrap.
- Latency: next-address decision is one cycle. A taken branch's target appears on ProgCtr the cycle after the branch is presented; there is no delay slot.
- Simultaneous events:
  - Reset dominates Start and Stall.
  - Start coincident with Reset is lost.
  - HALT_CODE dominates Stall and branch.
  - BranchEn=1 with Zero=0 is fall-through.
- Unknown/X on Instruction outside RUN has no effect.

Decomposition:
- Shared package: state enum {IDLE,RUN,STALL,DONE}, HALT_CODE, default PC_W.
- One natural sub-module, next_pc: combinational selector of ProgCtr+1 (wrapping) vs BranchTarget from BranchEn&Zero. It is reused by both the RUN and STALL release paths.
- FSM, counter and ProgCtr register stay in fetch_sequencer.

Test Plan:
1. Reset, then Start pulse; ROM holds 3 non-branch ops then HALT_CODE.
   - ProgCtr sequences 0,1,2,3.
   - Done=1 at the cycle after ProgCtr=3 is presented.
   - CycleCnt=4; ProgCtr stays 3.
2. At ProgCtr=5, BranchEn=1, Zero=1, BranchTarget=40 -> ProgCtr=40 next cycle. Same with Zero=0 -> ProgCtr=6.
3. Stall=1 for 3 cycles at ProgCtr=7:
   - ProgCtr holds 7 and InstrValid=0 during STALL.
   - ProgCtr=8 after Stall drops.
   - CycleCnt advances by 4 total across that instruction.
4. PC_W=4, straight-line code from 0 with no HALT_CODE -> ProgCtr wraps 15->0.
5. Reset asserted while in STALL at ProgCtr=12 -> next cycle IDLE, ProgCtr=0, Done=0, CycleCnt=0. A subsequent Start restarts at 0.
6. From DONE, assert Start -> ProgCtr=0, Done=0, CycleCnt=0, InstrValid=1 next cycle. Start during RUN has no effect on ProgCtr.
